// File: rtl/ps2_keypad_if.sv
// Keypad bus between the hps_io key-event side and the system1 switch inputs.
// The master drives key events and on-screen switches. The slave returns the switch levels.
interface ps2_keypad_if;
   logic [10:0] ps2_key;
   logic [24:0] sw_in;
   logic [24:0] sw;
   logic        swrst;
   logic        tick_ms;

   modport master (output ps2_key, sw_in, input sw, swrst, tick_ms);
   modport slave  (input ps2_key, sw_in, output sw, swrst, tick_ms);
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 event bus to system1 keypad switch levels.
// Key presses are stretched to a minimum hold time, and F1 becomes a timed reset pulse.
module ps2_keypad_lane #(
   parameter int HOLD_MS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic make,
   input  logic brk,
   input  logic tick,
   output logic lvl
);
   localparam int HW = $clog2(HOLD_MS + 1);

   logic          key_state;
   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_state <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         if (make)     key_state <= 1'b1;
         else if (brk) key_state <= 1'b0;
         // A make reloads the counter, and this takes priority over a tick that occurs on the same edge.
         if (make)                         hold_cnt <= HW'(HOLD_MS);
         else if (tick && hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
      end
   end

   assign lvl = key_state | (hold_cnt != '0);
endmodule

module ps2_keypad #(
   parameter int CLK_HZ  = 25000000,
   parameter int HOLD_MS = 20,
   parameter int RST_MS  = 50
) (
   input logic         clk,
   input logic         rst_n,
   ps2_keypad_if.slave bus
);
   localparam int NUM_LANES = 24;
   localparam int DIV       = CLK_HZ / 1000;
   localparam int PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int RW        = $clog2(RST_MS + 1);

   logic [PW-1:0]          pre;
   logic                   tick;
   logic                   primed, prev_toggle, evt;
   logic                   hit;
   logic [4:0]             idx;
   logic [NUM_LANES-1:0]   make_vec, brk_vec, key_lvl;
   logic                   f1_make;
   logic [RW-1:0]          rst_cnt;
   logic [24:0]            sw_q;

   wire       pressed = bus.ps2_key[9];
   wire       ext     = bus.ps2_key[8];
   wire [7:0] code    = bus.ps2_key[7:0];

   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + 1'b1;
   end

   // The first edge after reset only samples the toggle level.
   // This prevents a stale level from appearing as an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed      <= 1'b0;
         prev_toggle <= 1'b0;
      end else if (!primed) begin
         primed      <= 1'b1;
         prev_toggle <= bus.ps2_key[10];
      end else if (evt) begin
         prev_toggle <= bus.ps2_key[10];
      end
   end

   assign evt = primed && (bus.ps2_key[10] != prev_toggle);

   always_comb begin
      hit = 1'b1;
      idx = 5'd0;
      case ({ext, code})
         9'h045: idx = 5'd0;
         9'h016: idx = 5'd1;
         9'h01E: idx = 5'd2;
         9'h026: idx = 5'd3;
         9'h025: idx = 5'd4;
         9'h02E: idx = 5'd5;
         9'h036: idx = 5'd6;
         9'h03D: idx = 5'd7;
         9'h03E: idx = 5'd8;
         9'h046: idx = 5'd9;
         9'h01C: idx = 5'd10;
         9'h032: idx = 5'd11;
         9'h021: idx = 5'd12;
         9'h023: idx = 5'd13;
         9'h024: idx = 5'd14;
         9'h02B: idx = 5'd15;
         9'h03A: idx = 5'd16;
         9'h04B: idx = 5'd17;
         9'h034: idx = 5'd18;
         9'h02D: idx = 5'd19;
         9'h04D: idx = 5'd20;
         9'h175: idx = 5'd21;
         9'h01B: idx = 5'd22;
         9'h172: idx = 5'd23;
         9'h005: idx = 5'd24;
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      make_vec = '0;
      brk_vec  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         make_vec[i] = evt && hit && pressed  && (idx == 5'(i));
         brk_vec[i]  = evt && hit && !pressed && (idx == 5'(i));
      end
   end

   assign f1_make = evt && hit && pressed && (idx == 5'd24);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ps2_keypad_lane #(.HOLD_MS(HOLD_MS)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .make  (make_vec[i]),
         .brk   (brk_vec[i]),
         .tick  (tick),
         .lvl   (key_lvl[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      rst_cnt <= '0;
      else if (f1_make)                rst_cnt <= RW'(RST_MS);
      else if (tick && rst_cnt != '0)  rst_cnt <= rst_cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q <= '0;
      end else begin
         sw_q[23:0] <= key_lvl | bus.sw_in[23:0];
         sw_q[24]   <= (rst_cnt != '0) | bus.sw_in[24];
      end
   end

   assign bus.sw      = sw_q;
   assign bus.swrst   = sw_q[24];
   assign bus.tick_ms = tick;
endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: priming, tap stretch, extended codes, F1 pulse, concurrency, reset.
// The bench uses a 20-cycle millisecond so that the timed checks stay short.
module tb_ps2_keypad;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ps2_keypad_if bus ();

   ps2_keypad #(.CLK_HZ(20000), .HOLD_MS(20), .RST_MS(50)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int ticks, rise_c;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input bit p, input bit e, input logic [7:0] c);
      bus.ps2_key = {~bus.ps2_key[10], p, e, c};
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start this task at a negedge. It sends a make and counts the tick strobes that occur after
   // the decode edge. The count ends when output bit 'b' has risen and then fallen again.
   task automatic measure(input int b, input bit e, input logic [7:0] c, input int brk_at,
                          input int remake_at, output int n, output int rc);
      bit risen = 0;
      bit remade = 0;
      bit done = 0;
      n = 0;
      rc = -1;
      send(1, e, c);
      @(posedge clk);
      for (int k = 0; k < 4000 && !done; k++) begin
         @(negedge clk);
         if (risen && !bus.sw[b]) done = 1;
         else begin
            if (bus.sw[b] && !risen) begin risen = 1; rc = k; end
            if (bus.tick_ms) n++;
            if (k == brk_at) send(0, e, c);
            if (n == remake_at && !remade) begin remade = 1; send(1, e, c); end
         end
      end
      if (!done) n = 9999;
   endtask

   initial begin
      bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
      bus.sw_in   = '0;
      // 1: reset with toggle=1 held; priming must swallow it
      cyc(3);
      chk("rst_sw", bus.sw, 0);
      chk("rst_swrst", bus.swrst, 0);
      chk("rst_tick", bus.tick_ms, 0);
      rst_n = 1'b1;
      cyc(10);
      chk("prime_sw", bus.sw, 0);
      chk("prime_swrst", bus.swrst, 0);

      // 2: short tap of key 1
      measure(1, 0, 8'h16, 98, -1, ticks, rise_c);
      chk("tap_rise_cycle", rise_c, 1);
      chk("tap_ticks_19_20", (ticks >= 19 && ticks <= 20), 1);
      chk("tap_after_sw", bus.sw, 0);

      // 3: extended U held 40 ms
      @(negedge clk);
      send(1, 1, 8'h75);
      cyc(2);
      chk("ext_rise", bus.sw, 25'h0200000);
      begin
         int lows = 0;
         for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (!bus.sw[21]) lows++;
         end
         chk("ext_held_lows", lows, 0);
      end
      send(0, 1, 8'h75);
      @(posedge clk); #1;
      chk("ext_brk_edge1", bus.sw[21], 1);
      @(posedge clk); #1;
      chk("ext_brk_edge2", bus.sw[21], 0);
      @(negedge clk);
      send(1, 0, 8'h75);
      cyc(5);
      chk("ext_wrong_bit", bus.sw, 0);

      // 4: F1 pulse, then F1 re-made at 30 ms
      @(negedge clk);
      measure(24, 0, 8'h05, 0, -1, ticks, rise_c);
      chk("f1_rise_cycle", rise_c, 1);
      chk("f1_ticks_50", (ticks >= 49 && ticks <= 51), 1);
      chk("f1_swrst_low", bus.swrst, 0);
      @(negedge clk);
      measure(24, 0, 8'h05, 0, 30, ticks, rise_c);
      chk("f1_ext_ticks_80", (ticks >= 79 && ticks <= 81), 1);

      // 5: concurrent keys, plus sw_in merge
      @(negedge clk);
      send(1, 0, 8'h2E);
      cyc(1);
      send(1, 0, 8'h4D);
      cyc(10);
      chk("multi_both", bus.sw, 25'h0100020);
      send(0, 0, 8'h2E);
      cyc(450);
      chk("multi_sw5_low", bus.sw[5], 0);
      chk("multi_sw20_high", bus.sw[20], 1);
      bus.sw_in[5] = 1'b1;
      #1 chk("swin_before", bus.sw[5], 0);
      @(posedge clk); #1;
      chk("swin_sw5", bus.sw[5], 1);
      @(negedge clk);
      bus.sw_in = 25'h1000000;
      @(posedge clk); #1;
      chk("swin_swrst", {bus.swrst, bus.sw[24]}, 2'b11);
      @(negedge clk);
      bus.sw_in = '0;
      send(0, 0, 8'h4D);
      cyc(460);
      chk("multi_all_low", bus.sw, 0);

      // 6: reset mid-hold and mid-pulse
      send(1, 0, 8'h1C);
      cyc(1);
      send(1, 0, 8'h05);
      cyc(3);
      chk("mid_sw10", bus.sw[10], 1);
      chk("mid_swrst", bus.swrst, 1);
      #2 rst_n = 1'b0;
      bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
      #1;
      chk("async_sw", bus.sw, 0);
      chk("async_swrst", bus.swrst, 0);
      chk("async_tick", bus.tick_ms, 0);
      cyc(3);
      rst_n = 1'b1;
      cyc(10);
      chk("reprime_sw", bus.sw, 0);
      send(1, 0, 8'h1C);
      cyc(2);
      chk("reprime_event", bus.sw, 25'h0000400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
